// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
//   state_e : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_e : which port owns the transaction in flight
//   STREAK_W / DEF_MAX_D_STREAK : data-grant streak counter width and default limit
package mem_arb_pkg;

   localparam int unsigned STREAK_W         = 3;
   localparam int unsigned DEF_MAX_D_STREAK = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the core (fetch + data ports), the arbiter and the memory.
//   i_*   : instruction-fetch request/response
//   d_*   : data load/store request/response
//   m_*   : single-ported synchronous memory
//   busy  : arbiter not idle (PC hold)
// slave modport is the arbiter's view; master is the core/memory side.
interface mem_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_we;
   logic              m_re;
   logic [DATA_W-1:0] m_rdata;

   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_we, m_re, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_we, m_re, busy
   );

endinterface : mem_bus_arbiter_if

// File: rtl/mem_arb_fair_sel.sv
// Combinational winner selection between fetch (I) and data (D) requests.
//   i_req, d_req : raw requests
//   d_streak     : consecutive D grants taken while I was waiting
//   in_resp      : arbiter is in RESP; the owner's request is the one completing
//   owner        : current transaction owner
//   grant_c      : some port is eligible this cycle
//   winner_c     : the port that wins (meaningful only with grant_c)
module mem_arb_fair_sel
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
   input  logic                i_req,
   input  logic                d_req,
   input  logic [STREAK_W-1:0] d_streak,
   input  logic                in_resp,
   input  owner_e              owner,
   output logic                grant_c,
   output owner_e              winner_c
);

   logic i_elig_c;
   logic d_elig_c;

   // D has priority unless it has already used up its streak while I waits.
   always_comb begin
      i_elig_c = i_req & ~(in_resp & (owner == OWN_I));
      d_elig_c = d_req & ~(in_resp & (owner == OWN_D));
      grant_c  = i_elig_c | d_elig_c;
      winner_c = OWN_I;
      if (d_elig_c && !(i_elig_c && (d_streak == STREAK_W'(MAX_D_STREAK)))) begin
         winner_c = OWN_D;
      end
   end

endmodule : mem_arb_fair_sel

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter in front of one synchronous memory.
// A grant latches the winner's request into m_*; the next cycle (ACCESS)
// strobes m_re or m_we once; the cycle after (RESP) pulses the owner's ack.
// Load data is captured from m_rdata on the edge that closes the m_re cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_bus_arbiter_if.slave (core request/response + memory + busy)
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
   input  logic             clk,
   input  logic             rst,
   mem_bus_arbiter_if.slave bus
);

   state_e              state_q,    state_d;
   owner_e              owner_q,    owner_d;
   logic [STREAK_W-1:0] d_streak_q, d_streak_d;
   logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;
   logic                m_we_q,     m_we_d;
   logic                m_re_q,     m_re_d;
   logic                i_ack_q,    i_ack_d;
   logic                d_ack_q,    d_ack_d;
   logic [DATA_W-1:0]   i_rdata_q,  i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
   logic                busy_q,     busy_d;

   logic   grant_c;
   owner_e winner_c;
   logic   in_resp_c;
   logic   do_grant_c;

   assign in_resp_c = (state_q == RESP);

   mem_arb_fair_sel #(
      .MAX_D_STREAK (MAX_D_STREAK)
   ) u_fair_sel (
      .i_req    (bus.i_req),
      .d_req    (bus.d_req),
      .d_streak (d_streak_q),
      .in_resp  (in_resp_c),
      .owner    (owner_q),
      .grant_c  (grant_c),
      .winner_c (winner_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      d_streak_d = d_streak_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      m_we_d     = 1'b0;
      m_re_d     = 1'b0;
      i_ack_d    = 1'b0;
      d_ack_d    = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      do_grant_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            do_grant_c = grant_c;
         end
         ACCESS: begin
            state_d = RESP;
            if (owner_q == OWN_D) begin
               d_ack_d = 1'b1;
               if (m_re_q) d_rdata_d = bus.m_rdata;
            end else begin
               i_ack_d = 1'b1;
               if (m_re_q) i_rdata_d = bus.m_rdata;
            end
         end
         RESP: begin
            state_d    = IDLE;
            do_grant_c = grant_c;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Latch the winner and launch its memory access next cycle.
      if (do_grant_c) begin
         state_d = ACCESS;
         owner_d = winner_c;
         if (winner_c == OWN_D) begin
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_we_d    = bus.d_we;
            m_re_d    = ~bus.d_we;
         end else begin
            m_addr_d  = bus.i_addr;
            m_re_d    = 1'b1;
         end
         // Streak counts D grants only while I is waiting; saturates at the limit.
         if (!bus.i_req || (winner_c == OWN_I)) begin
            d_streak_d = '0;
         end else if (d_streak_q < STREAK_W'(MAX_D_STREAK)) begin
            d_streak_d = d_streak_q + STREAK_W'(1);
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_I;
         d_streak_q <= '0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         m_we_q     <= 1'b0;
         m_re_q     <= 1'b0;
         i_ack_q    <= 1'b0;
         d_ack_q    <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         d_streak_q <= d_streak_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         m_we_q     <= m_we_d;
         m_re_q     <= m_re_d;
         i_ack_q    <= i_ack_d;
         d_ack_q    <= d_ack_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_re    = m_re_q;
   assign bus.i_ack   = i_ack_q;
   assign bus.d_ack   = d_ack_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.busy    = busy_q;

endmodule : mem_bus_arbiter
